// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding and baud divisor computation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per bit, integer-truncated.
  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered count/full/empty; storage is not reset.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   wr_data,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [7:0]                   rd_data_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             wr_acc_c;
  logic             rd_acc_c;

  // A write against the registered full flag is dropped even if a pop happens this cycle.
  assign wr_acc_c  = wr_en && !full;
  assign rd_acc_c  = rd_en && !empty;
  assign rd_data_c = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    if (wr_acc_c && !rd_acc_c) begin
      count_d = count + CNT_W'(1);
    end else if (!wr_acc_c && rd_acc_c) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Byte storage.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally; status flags registered from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a back-to-back frame serialiser.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        data_in,
  input  logic                              wr_en,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              RsTx,
  output logic                              sending,
  output logic                              sent
);

  localparam int unsigned DIV    = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_q;
  logic [2:0]        bit_d;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              tx_d;
  logic              sent_d;
  logic              pop_c;
  logic              bit_end_c;
  logic              fifo_empty;
  logic [7:0]        head_c;

  // Byte buffer between the host write strobe and the serialiser.
  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (data_in),
    .wr_en     (wr_en),
    .rd_en     (pop_c),
    .rd_data_c (head_c),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty)
  );

  assign bit_end_c = (baud_q == BAUD_W'(DIV - 1));

  // Next-state, baud counter, bit index, shifter and line/pulse values.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = head_c;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    // Line level and end-of-frame pulse follow the upcoming cycle's state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    sent_d = (state_d == STOP) && (baud_d == BAUD_W'(DIV - 1));
  end

  // State and registered outputs; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      RsTx    <= 1'b1;
      sent    <= 1'b0;
      sending <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      RsTx    <= tx_d;
      sent    <= sent_d;
      sending <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at DIV=16, FIFO_DEPTH=4.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en;
  logic       full;
  logic [2:0] count;
  logic       RsTx;
  logic       sending;
  logic       sent;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  longint     start_times[$];
  longint     sent_times[$];
  int         sent_cnt = 0;
  longint     cyc = 0;

  // Line decoder state
  bit         busy = 1'b0;
  int         off  = 0;
  longint     fstart = 0;
  logic [7:0] rx = '0;

  uart_tx_buffered #(
    .CLOCK_FREQ (16),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .wr_en   (wr_en),
    .full    (full),
    .count   (count),
    .RsTx    (RsTx),
    .sending (sending),
    .sent    (sent)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: decodes frames mid-bit and checks them against the expected-byte queue.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst === 1'b1) begin
      busy = 1'b0;
    end else begin
      if (sent === 1'b1) begin
        sent_cnt++;
        sent_times.push_back(cyc);
        chk("sent_offset", 32'(cyc - fstart), 32'd159);
      end
      if (!busy) begin
        if (RsTx === 1'b0) begin
          busy   = 1'b1;
          off    = 0;
          fstart = cyc;
          start_times.push_back(cyc);
        end
      end else begin
        off++;
      end
      if (busy && (off % 16 == 8)) begin
        if (off / 16 == 0) begin
          chk("start_bit", 32'(RsTx), 32'd0);
        end else if (off / 16 <= 8) begin
          rx[off/16-1] = RsTx;
        end else begin
          chk("stop_bit", 32'(RsTx), 32'd1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", rx);
          end else begin
            chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
          busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] b);
    data_in = b;
    wr_en   = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sending === 1'b0 && count === 3'd0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int t0;
    int sc;
    bit hit;
    logic [7:0] burst[3];
    logic [7:0] five[5];

    burst = '{8'h55, 8'hAA, 8'h0F};
    five  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst = 1'b0; wr_en = 1'b0; data_in = '0;
    #2 rst = 1'b1;
    #2;
    chk("rst_RsTx", 32'(RsTx), 32'd1);
    chk("rst_sending", 32'(sending), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Single byte 0x41
    exp_q.push_back(8'h41);
    wr(8'h41);
    wr_en = 1'b0;
    chk("single_count_e0", 32'(count), 32'd1);
    chk("single_line_e0", 32'(RsTx), 32'd1);
    tick();
    chk("single_count_e1", 32'(count), 32'd0);
    chk("single_line_e1", 32'(RsTx), 32'd0);
    chk("single_sending", 32'(sending), 32'd1);
    wait_idle(400);
    chk("single_sent_cnt", 32'(sent_cnt), 32'd1);
    chk("single_idle_line", 32'(RsTx), 32'd1);

    // Burst of three back-to-back frames
    s0 = start_times.size();
    t0 = sent_times.size();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(burst[i]);
      wr(burst[i]);
    end
    wr_en = 1'b0;
    wait_idle(800);
    chk("burst_starts", 32'(start_times.size() - s0), 32'd3);
    chk("burst_sents", 32'(sent_times.size() - t0), 32'd3);
    if (start_times.size() - s0 == 3 && sent_times.size() - t0 == 3) begin
      chk("burst_gap01", 32'(start_times[s0+1] - start_times[s0]), 32'd160);
      chk("burst_gap12", 32'(start_times[s0+2] - start_times[s0+1]), 32'd160);
      chk("burst_sent01", 32'(sent_times[t0+1] - sent_times[t0]), 32'd160);
      chk("burst_sent12", 32'(sent_times[t0+2] - sent_times[t0+1]), 32'd160);
      chk("burst_total", 32'(sent_times[t0+2] - start_times[s0] + 1), 32'd480);
    end

    // Overflow: six writes, sixth dropped
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        chk("ovf_count_e3", 32'(count), 32'd3);
        chk("ovf_full_e3", 32'(full), 32'd0);
      end
      if (i == 5) begin
        chk("ovf_count_e4", 32'(count), 32'd4);
        chk("ovf_full_e4", 32'(full), 32'd1);
      end
      if (i < 5) exp_q.push_back(8'(i + 1));
      wr(8'(i + 1));
    end
    wr_en = 1'b0;
    chk("ovf_count_e5", 32'(count), 32'd4);
    chk("ovf_full_e5", 32'(full), 32'd1);
    wait_idle(1200);

    // Simultaneous pop and write while full
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(five[i]);
      wr(five[i]);
    end
    wr_en = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sent === 1'b1) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("sim_sent_seen", 32'(hit), 32'd1);
    chk("sim_count_pre", 32'(count), 32'd4);
    chk("sim_full_pre", 32'(full), 32'd1);
    data_in = 8'h66;
    wr_en   = 1'b1;
    tick();
    chk("sim_count_drop", 32'(count), 32'd3);
    chk("sim_full_drop", 32'(full), 32'd0);
    data_in = 8'h77;
    exp_q.push_back(8'h77);
    tick();
    wr_en = 1'b0;
    chk("sim_count_acc", 32'(count), 32'd4);
    chk("sim_full_acc", 32'(full), 32'd1);
    wait_idle(1200);

    // Reset during DATA bit 3 with two bytes queued
    wr(8'hC3);
    wr(8'h5A);
    wr(8'h96);
    wr_en = 1'b0;
    chk("rstm_count_pre", 32'(count), 32'd2);
    repeat (68) tick();
    chk("rstm_sending_pre", 32'(sending), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rstm_RsTx", 32'(RsTx), 32'd1);
    chk("rstm_count", 32'(count), 32'd0);
    chk("rstm_full", 32'(full), 32'd0);
    chk("rstm_sending", 32'(sending), 32'd0);
    sc = sent_cnt;
    repeat (3) tick();
    rst = 1'b0;
    repeat (200) tick();
    chk("rstm_no_sent", 32'(sent_cnt), 32'(sc));
    chk("rstm_idle_line", 32'(RsTx), 32'd1);
    exp_q.push_back(8'h33);
    wr(8'h33);
    wr_en = 1'b0;
    wait_idle(400);
    chk("rstm_clean_sent", 32'(sent_cnt), 32'(sc + 1));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
